safe_keypad_ctrl: RTL and testbench
===================================

Name: safe_keypad_ctrl

Overview:
Sequential successor to the combinational 4-bit safe comparator. Accepts a code as a stream of keypad digits, compares it against a stored code, and drives unlock and alarm outputs. Counts failed attempts and enforces a timed lockout. Sits between the keypad scanner and the lock actuator / indicator LEDs.

Parameters:
NUM_DIGITS, 4, digits per code (1..8)
DIGIT_W, 4, bits per digit
DEFAULT_CODE, 16'h2580, code loaded at reset; width NUM_DIGITS*DIGIT_W, first-entered digit in MSBs
MAX_TRIES, 3, consecutive failures that trigger lockout (>=1)
LOCKOUT_CYCLES, 1000, lockout duration in clk cycles (>=2)
UNLOCK_CYCLES, 500, open-window duration in clk cycles (>=2)

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
digit_valid  in  1  one-cycle strobe; digit is valid
digit  in  DIGIT_W  keypad digit value
enter  in  1  one-cycle strobe; submit entered digits
clear  in  1  one-cycle strobe; discard partial entry
lock_req  in  1  relock immediately while open
unlocked  out  1  safe open (replaces L0)
locked  out  1  complement of unlocked (replaces L1)
alarm  out  1  high for the whole lockout
fail_pulse  out  1  one-cycle pulse per rejected attempt
tries_left  out  $clog2(MAX_TRIES+1)  remaining attempts before lockout
digit_cnt  out  $clog2(NUM_DIGITS+2)  digits captured in the current entry

Behaviour:
- Reset, one clk with rst=1: state=ENTRY, unlocked=0, locked=1, alarm=0, fail_pulse=0, tries_left=MAX_TRIES, digit_cnt=0, entry shift register=0, code register=DEFAULT_CODE, timer=0. Reset mid-operation aborts any entry, lockout or open window.
- States: ENTRY, OPEN, LOCKOUT.
- ENTRY, input priority is clear > enter > digit_valid.
  - clear: entry register=0, digit_cnt=0. A simultaneous enter or digit is dropped.
  - digit_valid: shift digit into the LSBs of the entry register. digit_cnt increments and saturates at NUM_DIGITS+1, where +1 flags overflow.
  - enter: the attempt passes only if digit_cnt==NUM_DIGITS and entry==code. A same-cycle digit is dropped. The entry register and digit_cnt clear on the next edge in every case.
  - Pass: next cycle state=OPEN, unlocked=1, tries_left=MAX_TRIES. Latency is 1 cycle from the enter edge.
  - Fail, including too few digits, overflow, or enter with zero digits: fail_pulse=1 for one cycle and tries_left decrements. If it reaches 0: state=LOCKOUT, alarm=1, timer loaded with LOCKOUT_CYCLES-1, all in the same cycle as fail_pulse.
- OPEN: unlocked=1 for exactly UNLOCK_CYCLES cycles, then state=ENTRY, unlocked=0.
  - lock_req relocks on the next edge and takes priority over timer expiry.
  - digit_valid and enter are ignored, except under the optional feature.
- LOCKOUT: all keypad inputs are ignored.
  - alarm=1 for exactly LOCKOUT_CYCLES cycles.
  - Then state=ENTRY, alarm=0, tries_left=MAX_TRIES.
- locked == ~unlocked at all times.
- Comparison is a full-width equality on NUM_DIGITS*DIGIT_W bits. No partial-match leakage: all outputs are independent of which digit mismatched.

Optional Feature:
SAFE_CODE_CHANGE_EN.
- Defined: in OPEN, digit_valid shifts into the entry register (same rules as ENTRY). On enter with digit_cnt==NUM_DIGITS, the code register takes the entry, the open timer restarts at UNLOCK_CYCLES, and the safe stays open. On enter with the wrong count, the entry is discarded and the code is unchanged, with no fail_pulse and no tries_left change. The new code persists until rst, which restores DEFAULT_CODE.
- Undefined: the code register is the constant DEFAULT_CODE, and keypad inputs in OPEN are ignored.

Decomposition:
- Shared package safe_pkg holds:
  - the state enum (ENTRY, OPEN, LOCKOUT);
  - localparams CODE_W=NUM_DIGITS*DIGIT_W and the counter widths;
  - a function for the saturating digit-count increment.
- One sub-module, safe_timer: a loadable down-counter with load, load_val and a done flag. One instance is shared between OPEN and LOCKOUT, since they are mutually exclusive.

Test Plan:
- Correct entry: rst, then digits 2,5,8,0 and enter. Expect unlocked=1 on the next cycle, tries_left=3, unlocked held for exactly 500 cycles, then locked=1.
- Wrong entry: digits 2,5,8,1 and enter. Expect fail_pulse for one cycle, tries_left 3→2, unlocked stays 0. Then the correct code opens the safe and tries_left returns to 3.
- Lockout: three wrong entries. On the third, fail_pulse=1 and alarm=1 in the same cycle. Digits 2,5,8,0 + enter during lockout produce no unlock. alarm drops after exactly 1000 cycles and tries_left=3.
- Malformed entries: 3 digits + enter → fail. 5 digits (2,5,8,0,0) + enter → fail, digit_cnt saturates at 5. clear asserted with enter in the same cycle → no attempt counted.
- Relock and reset: open with the correct code, lock_req at cycle 10 → unlocked=0 on the next edge. Reopen, assert rst at cycle 3 of the window → all outputs at reset values on the next edge.
- With SAFE_CODE_CHANGE_EN: open, enter 1,1,0,0 + enter. Relock; 2,5,8,0 now fails and 1,1,0,0 opens. After rst, 2,5,8,0 opens again.

Source files
------------

// File: rtl/safe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : safe_pkg
// Description : Shared types, default widths and helpers for safe_keypad_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
package safe_pkg;

    typedef enum logic [1:0] {
        ENTRY   = 2'd0,
        OPEN    = 2'd1,
        LOCKOUT = 2'd2
    } state_t;

    localparam int C_NUM_DIGITS = 4;
    localparam int C_DIGIT_W    = 4;
    localparam int C_MAX_TRIES  = 3;
    localparam int C_CODE_W     = C_NUM_DIGITS * C_DIGIT_W;
    localparam int C_CNT_W      = $clog2(C_NUM_DIGITS + 2);
    localparam int C_TRIES_W    = $clog2(C_MAX_TRIES + 1);

    // Digit count saturates at lim so overflow stays visible until enter/clear.
    function automatic logic [7:0] sat_inc(input logic [7:0] cnt, input logic [7:0] lim);
        return (cnt >= lim) ? cnt : cnt + 8'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/safe_timer.sv
`default_nettype none
// ============================================================================
// Module      : safe_timer
// Description : Loadable down-counter; o_done is high while the count is zero.
// Revision    : 1.0 - initial release
// ============================================================================
module safe_timer #(
    parameter int WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    output logic             o_done
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/safe_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : safe_keypad_ctrl
// Description : Keypad code entry, unlock window and failed-attempt lockout.
//               Optional macro SAFE_CODE_CHANGE_EN allows re-coding while open.
// Revision    : 1.0 - initial release
// ============================================================================
module safe_keypad_ctrl
    import safe_pkg::*;
#(
    parameter int                                   NUM_DIGITS     = C_NUM_DIGITS,
    parameter int                                   DIGIT_W        = C_DIGIT_W,
    parameter logic [NUM_DIGITS*DIGIT_W-1:0]        DEFAULT_CODE   = 16'h2580,
    parameter int                                   MAX_TRIES      = C_MAX_TRIES,
    parameter int                                   LOCKOUT_CYCLES = 1000,
    parameter int                                   UNLOCK_CYCLES  = 500
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                digit_valid,
    input  logic [DIGIT_W-1:0]                  digit,
    input  logic                                enter,
    input  logic                                clear,
    input  logic                                lock_req,
    output logic                                unlocked,
    output logic                                locked,
    output logic                                alarm,
    output logic                                fail_pulse,
    output logic [$clog2(MAX_TRIES+1)-1:0]      tries_left,
    output logic [$clog2(NUM_DIGITS+2)-1:0]     digit_cnt
);

    localparam int CODE_W  = NUM_DIGITS * DIGIT_W;
    localparam int CNT_W   = $clog2(NUM_DIGITS + 2);
    localparam int TRIES_W = $clog2(MAX_TRIES + 1);
    localparam int TMR_MAX = (LOCKOUT_CYCLES > UNLOCK_CYCLES) ? LOCKOUT_CYCLES : UNLOCK_CYCLES;
    localparam int TMR_W   = $clog2(TMR_MAX);

    localparam logic [CNT_W-1:0]   C_FULL       = CNT_W'(NUM_DIGITS);
    localparam logic [TRIES_W-1:0] C_TRIES_INIT = TRIES_W'(MAX_TRIES);
    localparam logic [TMR_W-1:0]   C_OPEN_LOAD  = TMR_W'(UNLOCK_CYCLES - 1);
    localparam logic [TMR_W-1:0]   C_LOCK_LOAD  = TMR_W'(LOCKOUT_CYCLES - 1);

    state_t               r_state, w_state_nxt;
    logic [CODE_W-1:0]    r_entry, w_entry_nxt, w_entry_shift, w_code;
    logic [CNT_W-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [TRIES_W-1:0]   r_tries, w_tries_nxt;
    logic                 r_fail, w_fail_nxt;
    logic                 w_load, w_tmr_done, w_match;
    logic [TMR_W-1:0]     w_load_val;

    assign w_entry_shift = (r_entry << DIGIT_W) | CODE_W'(digit);
    assign w_cnt_inc     = CNT_W'(sat_inc(8'(r_cnt), 8'(NUM_DIGITS + 1)));
    // Full-width compare only: no per-digit information reaches any output.
    assign w_match       = (r_cnt == C_FULL) && (r_entry == w_code);

`ifdef SAFE_CODE_CHANGE_EN
    logic              w_code_we;
    logic [CODE_W-1:0] r_code;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_code <= DEFAULT_CODE;
        end else if (w_code_we) begin
            r_code <= r_entry;
        end
    end

    assign w_code = r_code;
`else
    assign w_code = DEFAULT_CODE;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_entry_nxt = r_entry;
        w_cnt_nxt   = r_cnt;
        w_tries_nxt = r_tries;
        w_fail_nxt  = 1'b0;
        w_load      = 1'b0;
        w_load_val  = '0;
`ifdef SAFE_CODE_CHANGE_EN
        w_code_we   = 1'b0;
`endif
        case (r_state)
            ENTRY: begin
                if (clear) begin
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                end else if (enter) begin
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                    if (w_match) begin
                        w_state_nxt = OPEN;
                        w_tries_nxt = C_TRIES_INIT;
                        w_load      = 1'b1;
                        w_load_val  = C_OPEN_LOAD;
                    end else begin
                        w_fail_nxt  = 1'b1;
                        w_tries_nxt = r_tries - TRIES_W'(1);
                        if (r_tries == TRIES_W'(1)) begin
                            w_state_nxt = LOCKOUT;
                            w_load      = 1'b1;
                            w_load_val  = C_LOCK_LOAD;
                        end
                    end
                end else if (digit_valid) begin
                    w_entry_nxt = w_entry_shift;
                    w_cnt_nxt   = w_cnt_inc;
                end
            end
            OPEN: begin
                if (lock_req) begin
                    w_state_nxt = ENTRY;
                    w_entry_nxt = '0;
                    w_cnt_nxt   = '0;
                end else begin
`ifdef SAFE_CODE_CHANGE_EN
                    if (clear) begin
                        w_entry_nxt = '0;
                        w_cnt_nxt   = '0;
                    end else if (enter) begin
                        w_entry_nxt = '0;
                        w_cnt_nxt   = '0;
                        if (r_cnt == C_FULL) begin
                            w_code_we  = 1'b1;
                            w_load     = 1'b1;
                            w_load_val = C_OPEN_LOAD;
                        end
                    end else if (digit_valid) begin
                        w_entry_nxt = w_entry_shift;
                        w_cnt_nxt   = w_cnt_inc;
                    end
`endif
                    // A code-change restart outranks expiry in the same cycle.
                    if (w_tmr_done && !w_load) begin
                        w_state_nxt = ENTRY;
                        w_entry_nxt = '0;
                        w_cnt_nxt   = '0;
                    end
                end
            end
            LOCKOUT: begin
                if (w_tmr_done) begin
                    w_state_nxt = ENTRY;
                    w_tries_nxt = C_TRIES_INIT;
                end
            end
            default: begin
                w_state_nxt = ENTRY;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ENTRY;
            r_entry <= '0;
            r_cnt   <= '0;
            r_tries <= C_TRIES_INIT;
            r_fail  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_entry <= w_entry_nxt;
            r_cnt   <= w_cnt_nxt;
            r_tries <= w_tries_nxt;
            r_fail  <= w_fail_nxt;
        end
    end

    safe_timer #(
        .WIDTH (TMR_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_load     (w_load),
        .i_load_val (w_load_val),
        .o_done     (w_tmr_done)
    );

    assign unlocked   = (r_state == OPEN);
    assign locked     = (r_state != OPEN);
    assign alarm      = (r_state == LOCKOUT);
    assign fail_pulse = r_fail;
    assign tries_left = r_tries;
    assign digit_cnt  = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_safe_keypad_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_safe_keypad_ctrl
// Description : Self-checking bench for safe_keypad_ctrl (digit-queue model).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_safe_keypad_ctrl;

    localparam int M_ENTRY = 0;
    localparam int M_OPEN  = 1;
    localparam int M_LOCK  = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       digit_valid = 1'b0;
    logic [3:0] digit = 4'd0;
    logic       enter = 1'b0;
    logic       clear = 1'b0;
    logic       lock_req = 1'b0;
    logic       unlocked, locked, alarm, fail_pulse;
    logic [1:0] tries_left;
    logic [2:0] digit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    safe_keypad_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .digit_valid (digit_valid),
        .digit       (digit),
        .enter       (enter),
        .clear       (clear),
        .lock_req    (lock_req),
        .unlocked    (unlocked),
        .locked      (locked),
        .alarm       (alarm),
        .fail_pulse  (fail_pulse),
        .tries_left  (tries_left),
        .digit_cnt   (digit_cnt)
    );

    always #5 clk = ~clk;

    // Model: mode, queue of keyed digits, remaining window cycles.
    int m_mode  = M_ENTRY;
    int m_q[$];
    int m_code[4] = '{2, 5, 8, 0};
    int m_tries = 3;
    int m_left  = 0;
    bit m_fail  = 1'b0;
    bit m_valid = 1'b0;

    function automatic bit code_ok();
        if (m_q.size() != 4) return 1'b0;
        for (int i = 0; i < 4; i++) if (m_q[i] != m_code[i]) return 1'b0;
        return 1'b1;
    endfunction

    always @(posedge clk) begin
        bit restarted;
        restarted = 1'b0;
        m_fail = 1'b0;
        if (rst) begin
            m_valid = 1'b1;
            m_mode  = M_ENTRY;
            m_q.delete();
            m_code  = '{2, 5, 8, 0};
            m_tries = 3;
            m_left  = 0;
        end else if (m_valid) begin
            case (m_mode)
                M_ENTRY: begin
                    if (clear) m_q.delete();
                    else if (enter) begin
                        if (code_ok()) begin
                            m_mode = M_OPEN; m_left = 500; m_tries = 3;
                        end else begin
                            m_fail = 1'b1; m_tries--;
                            if (m_tries == 0) begin m_mode = M_LOCK; m_left = 1000; end
                        end
                        m_q.delete();
                    end else if (digit_valid) m_q.push_back(int'(digit));
                end
                M_OPEN: begin
                    if (lock_req) begin
                        m_mode = M_ENTRY; m_q.delete();
                    end else begin
`ifdef SAFE_CODE_CHANGE_EN
                        if (clear) m_q.delete();
                        else if (enter) begin
                            if (m_q.size() == 4) begin
                                for (int i = 0; i < 4; i++) m_code[i] = m_q[i];
                                restarted = 1'b1; m_left = 500;
                            end
                            m_q.delete();
                        end else if (digit_valid) m_q.push_back(int'(digit));
`endif
                        if (!restarted) begin
                            m_left--;
                            if (m_left == 0) begin m_mode = M_ENTRY; m_q.delete(); end
                        end
                    end
                end
                default: begin
                    m_left--;
                    if (m_left == 0) begin m_mode = M_ENTRY; m_tries = 3; end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        logic [8:0] exp_v, act_v;
        int cnt;
        if (m_valid) begin
            cnt   = (m_q.size() > 5) ? 5 : m_q.size();
            exp_v = {m_mode == M_OPEN, m_mode != M_OPEN, m_mode == M_LOCK, m_fail,
                     2'(m_tries), 3'(cnt)};
            act_v = {unlocked, locked, alarm, fail_pulse, tries_left, digit_cnt};
            n_tests++;
            if (act_v !== exp_v) begin
                n_fail++;
                $display("FAIL model t=%0t got {unl,lck,alm,fp,tries,cnt}=%b required %b",
                         $time, act_v, exp_v);
            end
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit dv, input int d, input bit en, input bit cl, input bit lr);
        digit_valid = dv; digit = 4'(d); enter = en; clear = cl; lock_req = lr;
        @(negedge clk);
        digit_valid = 1'b0; enter = 1'b0; clear = 1'b0; lock_req = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic key(input int d);
        step(1'b1, d, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic code4(input int a, input int b, input int c, input int d);
        key(a); key(b); key(c); key(d);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int n;
        @(negedge clk);
        do_reset();
        chk("rst_unlocked", unlocked, 0);
        chk("rst_locked", locked, 1);
        chk("rst_alarm", alarm, 0);
        chk("rst_tries", tries_left, 3);
        chk("rst_cnt", digit_cnt, 0);

        // Correct code and open-window length
        code4(2, 5, 8, 0);
        chk("open_unlocked", unlocked, 1);
        chk("open_tries", tries_left, 3);
        n = 1;
        while (n < 600) begin idle(1); if (!unlocked) break; n++; end
        chk("open_len", n, 500);
        chk("open_relocked", locked, 1);

        // Wrong code, then correct code restores tries
        code4(2, 5, 8, 1);
        chk("wrong_fp", fail_pulse, 1);
        chk("wrong_tries", tries_left, 2);
        chk("wrong_unlocked", unlocked, 0);
        idle(1);
        chk("wrong_fp_single", fail_pulse, 0);
        code4(2, 5, 8, 0);
        chk("reopen_tries", tries_left, 3);
        idle(8);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("lockreq_unlocked", unlocked, 0);

        // Lockout
        code4(1, 1, 1, 1);
        code4(2, 5, 8, 1);
        code4(9, 9, 9, 9);
        chk("lock_fp", fail_pulse, 1);
        chk("lock_alarm", alarm, 1);
        code4(2, 5, 8, 0);
        chk("lock_no_unlock", unlocked, 0);
        n = 6;
        while (n < 1100) begin idle(1); if (!alarm) break; n++; end
        chk("lock_len", n, 1000);
        chk("lock_tries_back", tries_left, 3);

        // Malformed entries
        key(2); key(5); key(8);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("short_fp", fail_pulse, 1);
        key(2); key(5); key(8); key(0); key(0);
        chk("over_cnt", digit_cnt, 5);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("over_fp", fail_pulse, 1);
        chk("over_tries", tries_left, 1);
        key(2);
        step(1'b0, 0, 1'b1, 1'b1, 1'b0);
        chk("clr_enter_fp", fail_pulse, 0);
        chk("clr_enter_tries", tries_left, 1);
        chk("clr_enter_cnt", digit_cnt, 0);
        step(1'b0, 0, 1'b1, 1'b0, 1'b0);
        chk("empty_fp", fail_pulse, 1);
        chk("empty_alarm", alarm, 1);
        n = 1;
        while (n < 1100) begin idle(1); if (!alarm) break; n++; end
        chk("lock2_len", n, 1000);

        // Reset inside the open window
        code4(2, 5, 8, 0);
        idle(2);
        do_reset();
        chk("midrst_unlocked", unlocked, 0);
        chk("midrst_tries", tries_left, 3);
        chk("midrst_cnt", digit_cnt, 0);

`ifdef SAFE_CODE_CHANGE_EN
        code4(2, 5, 8, 0);
        code4(1, 1, 0, 0);
        chk("chg_still_open", unlocked, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        code4(2, 5, 8, 0);
        chk("chg_old_fails", fail_pulse, 1);
        code4(1, 1, 0, 0);
        chk("chg_new_opens", unlocked, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
        do_reset();
        code4(2, 5, 8, 0);
        chk("chg_rst_default", unlocked, 1);
        step(1'b0, 0, 1'b0, 1'b0, 1'b1);
`endif

        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1);
    end

endmodule
`default_nettype wire
